// File: rtl/des_round_iter.sv
// Iterative DES round engine: 16 Feistel rounds, one per clock, key schedule computed on the fly.
// Optional key-byte odd-parity flag enabled with `define DES_KEY_PARITY_CHK_EN.
module des_round_iter #(
  parameter logic EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic        key_parity_err
`endif
);

  // Tables list DES bit numbers, bit 1 being the MSB of the source vector.
  localparam int PC1_T [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48]   = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                 8, 9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,
                                24,25,26,27,28,29,28,29,30,31,32, 1};
  localparam int P_T [32]   = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                 2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam logic [3:0] SBOX_T [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o = {o[54:0], k[6'(64 - PC1_T[i])]};
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], cd[6'(56 - PC2_T[i])]};
    return o;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] r);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], r[5'(32 - E_T[i])]};
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o = {o[30:0], x[5'(32 - P_T[i])]};
    return o;
  endfunction

  // Each 6-bit group: row from the outer bits, column from the inner four.
  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] o;
    logic [47:0] t;
    logic [5:0]  six;
    o = '0;
    t = x;
    for (int b = 0; b < 8; b++) begin
      six = t[47:42];
      t   = t << 6;
      o   = {o[27:0], SBOX_T[{3'(b), six[5], six[0], six[4:1]}]};
    end
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rnd;
  logic [31:0] l_q, r_q, l_new, r_new, f_out;
  logic [27:0] c_q, d_q, c_rot, d_rot;
  logic [4:0]  s_idx;
  logic        two_shift;
  logic [47:0] subkey;
  logic        accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    s_idx     = EN ? rnd : 5'd17 - rnd;
    two_shift = !(s_idx inside {5'd1, 5'd2, 5'd9, 5'd16});
    if (EN) begin
      c_rot = two_shift ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
      d_rot = two_shift ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
    end else begin
      c_rot = two_shift ? {c_q[1:0], c_q[27:2]} : {c_q[0], c_q[27:1]};
      d_rot = two_shift ? {d_q[1:0], d_q[27:2]} : {d_q[0], d_q[27:1]};
    end
    // Encrypt keys off the freshly rotated halves; decrypt keys off the stored ones, then rotates back.
    subkey = pc2(EN ? {c_rot, d_rot} : {c_q, d_q});
    f_out  = p_perm(sbox(e_exp(r_q) ^ subkey));
    l_new  = r_q;
    r_new  = l_q ^ f_out;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (rnd == 5'd16) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      rnd      <= '0;
      data_out <= '0;
    end else if (accept) begin
      {l_q, r_q} <= data_in;
      {c_q, d_q} <= pc1(key);
      rnd        <= 5'd1;
    end else if (state_q == RUN) begin
      l_q <= l_new;
      r_q <= r_new;
      c_q <= c_rot;
      d_q <= d_rot;
      if (rnd == 5'd16) data_out <= {r_new, l_new};
      else              rnd      <= rnd + 5'd1;
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic       parity_fail;
  logic [63:0] key_sh;

  always_comb begin
    parity_fail = 1'b0;
    key_sh      = key;
    for (int b = 0; b < 8; b++) begin
      if (!(^key_sh[7:0])) parity_fail = 1'b1;
      key_sh = key_sh >> 8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      key_parity_err <= 1'b0;
    else if (accept) key_parity_err <= parity_fail;
  end
`else
  logic unused_key_parity;
  assign unused_key_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
`endif

endmodule

// File: tb/tb_des_round_iter.sv
// Directed bench for des_round_iter: one encrypt and one decrypt instance driven with known DES vectors.
// Second vector comes from the DES complementation property: ~key, ~block give ~result.
module tb_des_round_iter;

  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_C = 64'hECCBA8866443200E;
  localparam logic [63:0] BLK_A = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] OUT_A = 64'h0A4CD99543423234;
  localparam logic [63:0] BLK_B = 64'h33FF33000F550F55;
  localparam logic [63:0] OUT_B = 64'hF5B3266ABCBDCDCB;
  localparam logic [47:0] K1    = 48'h1B02EFFC7072;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        e_in_valid = 1'b0, e_out_ready = 1'b0;
  logic [63:0] e_data_in = '0, e_key = '0;
  logic        e_in_ready, e_out_valid, e_busy;
  logic [63:0] e_data_out;
  logic        d_in_valid = 1'b0, d_out_ready = 1'b0;
  logic [63:0] d_data_in = '0, d_key = '0;
  logic        d_in_ready, d_out_valid, d_busy;
  logic [63:0] d_data_out;
`ifdef DES_KEY_PARITY_CHK_EN
  logic        e_kpe, d_kpe;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_round_iter #(.EN(1'b1)) dut_enc (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .data_in(e_data_in), .key(e_key), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .data_out(e_data_out), .busy(e_busy)
`ifdef DES_KEY_PARITY_CHK_EN
    , .key_parity_err(e_kpe)
`endif
  );

  des_round_iter #(.EN(1'b0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .data_in(d_data_in), .key(d_key), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .data_out(d_data_out), .busy(d_busy)
`ifdef DES_KEY_PARITY_CHK_EN
    , .key_parity_err(d_kpe)
`endif
  );

  task automatic send_enc(input logic [63:0] d, input logic [63:0] k);
    e_in_valid = 1'b1;
    e_data_in  = d;
    e_key      = k;
    @(posedge clk); #1;
    e_in_valid = 1'b0;
  endtask

  task automatic wait_enc(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (e_out_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (e_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", e_in_ready); end
    n_cmp++; if (e_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", e_out_valid); end
    n_cmp++; if (e_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", e_busy); end
    n_cmp++; if (e_data_out !== 64'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", e_data_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    int cyc;
    e_out_ready = 1'b1;
    send_enc(BLK_A, KEY);
    n_cmp++; if (dut_enc.subkey !== K1) begin n_err++; $display("FAIL enc_k1: got %h want %h", dut_enc.subkey, K1); end
    n_cmp++; if (e_busy !== 1'b1 || e_in_ready !== 1'b0) begin n_err++; $display("FAIL enc_run_flags: busy=%b in_ready=%b want 1/0", e_busy, e_in_ready); end
    wait_enc(cyc);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL enc_latency: got %0d want 16", cyc); end
    n_cmp++; if (e_data_out !== OUT_A) begin n_err++; $display("FAIL enc_data: got %h want %h", e_data_out, OUT_A); end
    @(posedge clk); #1;
    n_cmp++; if (e_out_valid !== 1'b0 || e_in_ready !== 1'b1) begin n_err++; $display("FAIL enc_handshake: out_valid=%b in_ready=%b want 0/1", e_out_valid, e_in_ready); end
  endtask

  task automatic test_decrypt();
    int cyc;
    d_out_ready = 1'b1;
    d_in_valid  = 1'b1;
    d_data_in   = OUT_A;
    d_key       = KEY;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (d_out_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL dec_latency: got %0d want 16", cyc); end
    n_cmp++; if (d_data_out !== BLK_A) begin n_err++; $display("FAIL dec_data: got %h want %h", d_data_out, BLK_A); end
    @(posedge clk); #1;
    n_cmp++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin n_err++; $display("FAIL dec_handshake: out_valid=%b in_ready=%b want 0/1", d_out_valid, d_in_ready); end
  endtask

  task automatic test_backpressure();
    int cyc;
    e_out_ready = 1'b0;
    send_enc(BLK_B, KEY_C);
    wait_enc(cyc);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL bp_latency: got %0d want 16", cyc); end
    for (int i = 0; i < 5; i++) begin
      e_in_valid = (i % 2 == 0);
      e_data_in  = 64'(i + 1) * 64'h1111111111111111;
      @(posedge clk); #1;
      n_cmp++;
      if (e_data_out !== OUT_B || e_out_valid !== 1'b1 || e_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: data=%h valid=%b in_ready=%b want %h/1/0", i, e_data_out, e_out_valid, e_in_ready, OUT_B);
      end
    end
    e_in_valid  = 1'b0;
    e_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (e_out_valid !== 1'b0 || e_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", e_out_valid, e_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (e_busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept: busy=%b want 0", e_busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    e_out_ready = 1'b1;
    e_in_valid  = 1'b1;
    e_data_in   = BLK_A;
    e_key       = KEY;
    @(posedge clk); #1;
    e_data_in = BLK_B;
    e_key     = KEY_C;
    wait_enc(cyc);
    n_cmp++; if (cyc !== 16 || e_data_out !== OUT_A) begin n_err++; $display("FAIL b2b_first: cyc=%0d data=%h want 16/%h", cyc, e_data_out, OUT_A); end
    @(posedge clk); #1;
    n_cmp++; if (e_in_ready !== 1'b1 || e_busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap: in_ready=%b busy=%b want 1/0", e_in_ready, e_busy); end
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    n_cmp++; if (e_busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: busy=%b want 1", e_busy); end
    wait_enc(cyc);
    n_cmp++; if (cyc !== 16 || e_data_out !== OUT_B) begin n_err++; $display("FAIL b2b_second: cyc=%0d data=%h want 16/%h", cyc, e_data_out, OUT_B); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_enc(BLK_A, KEY);
    repeat (7) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (dut_enc.rnd !== 5'd8) begin n_err++; $display("FAIL mid_rnd: got %0d want 8", dut_enc.rnd); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (e_out_valid !== 1'b0 || e_in_ready !== 1'b1 || e_busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags: valid=%b in_ready=%b busy=%b want 0/1/0", e_out_valid, e_in_ready, e_busy); end
    n_cmp++; if (e_data_out !== 64'h0) begin n_err++; $display("FAIL mid_reset_data: got %h want 0", e_data_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_enc(BLK_B, KEY_C);
    wait_enc(cyc);
    n_cmp++; if (cyc !== 16 || e_data_out !== OUT_B) begin n_err++; $display("FAIL mid_after: cyc=%0d data=%h want 16/%h", cyc, e_data_out, OUT_B); end
    @(posedge clk); #1;
  endtask

`ifdef DES_KEY_PARITY_CHK_EN
  task automatic test_key_parity();
    int cyc;
    logic [63:0] y;
    e_out_ready = 1'b1;
    // Every byte of KEY has odd parity.
    send_enc(BLK_A, KEY);
    n_cmp++; if (e_kpe !== 1'b0) begin n_err++; $display("FAIL par_good: got %b want 0", e_kpe); end
    wait_enc(cyc);
    @(posedge clk); #1;
    // Last byte F0 has even parity; parity bits never reach the datapath.
    send_enc(BLK_A, 64'h133457799BBCDFF0);
    n_cmp++; if (e_kpe !== 1'b1) begin n_err++; $display("FAIL par_bad: got %b want 1", e_kpe); end
    wait_enc(cyc);
    n_cmp++; if (e_data_out !== OUT_A || e_kpe !== 1'b1) begin n_err++; $display("FAIL par_bad_data: data=%h err=%b want %h/1", e_data_out, e_kpe, OUT_A); end
    @(posedge clk); #1;
    // Weak key: the round stage applied twice returns the original block.
    send_enc(BLK_A, 64'h0101010101010101);
    n_cmp++; if (e_kpe !== 1'b0) begin n_err++; $display("FAIL par_weak: got %b want 0", e_kpe); end
    wait_enc(cyc);
    y = e_data_out;
    @(posedge clk); #1;
    send_enc(y, 64'h0101010101010101);
    wait_enc(cyc);
    n_cmp++; if (e_data_out !== BLK_A) begin n_err++; $display("FAIL par_weak_data: got %h want %h", e_data_out, BLK_A); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef DES_KEY_PARITY_CHK_EN
    test_key_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
